// File: rtl/instr_encoder_if.sv
// Request/response bundle between an instruction source and the encoder.
// The slave side is the encoder; the master side issues requests and drains words.
// Flow control is valid/ready on both the request and the output channel.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_class;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;
  logic [15:0] words_out;

  modport master (
    output in_valid, in_class, funct3, funct7b5, rd, rs1, rs2, imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, err, words_out
  );

  modport slave (
    input  in_valid, in_class, funct3, funct7b5, rd, rs1, rs2, imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, err, words_out
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes field-level requests into RV32I words with sequential byte addresses.
// Latency: 1 cycle from accept to out_valid; one word of buffering.
// Backpressure: in_ready follows out_ready while a word is held; clear blocks both channels.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  instr_encoder_if.slave bus
);

  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  // Address of the last slot before the address counter returns to the base.
  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (DEPTH - 1));

  localparam logic [2:0] C_LOAD   = 3'd0;
  localparam logic [2:0] C_STORE  = 3'd1;
  localparam logic [2:0] C_RTYPE  = 3'd2;
  localparam logic [2:0] C_BRANCH = 3'd3;
  localparam logic [2:0] C_ITYPE  = 3'd4;
  localparam logic [2:0] C_JAL    = 3'd5;

  logic        state;
  logic [31:0] instr_r;
  logic [31:0] addr_r;
  logic [15:0] words_r;
  logic        err_r;

  logic        accept;
  logic        xfer;
  logic        legal;
  logic [31:0] enc;
  logic [6:0]  funct7;

  // rst_n gates in_ready so nothing is advertised while reset is held.
  assign bus.in_ready  = rst_n && !clear && ((state == EMPTY) || bus.out_ready);
  assign bus.out_valid = (state == FULL);
  assign bus.out_instr = instr_r;
  assign bus.out_addr  = addr_r;
  assign bus.words_out = words_r;
  assign bus.err       = err_r;

  assign accept = bus.in_valid && bus.in_ready;
  assign xfer   = bus.out_valid && bus.out_ready && !clear;
  assign funct7 = {1'b0, bus.funct7b5, 5'b00000};

  // Format selection and legality; odd offsets are unreachable for branch/jump targets.
  always_comb begin
    enc   = 32'h0;
    legal = 1'b1;
    case (bus.in_class)
      C_LOAD:   enc = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, 7'b0000011};
      C_STORE:  enc = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], 7'b0100011};
      C_RTYPE:  enc = {funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, 7'b0110011};
      C_BRANCH: begin
        enc   = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                 bus.imm[4:1], bus.imm[11], 7'b1100011};
        legal = !bus.imm[0];
      end
      C_ITYPE: begin
        if (bus.funct3 == 3'b101)
          enc = {funct7, bus.imm[4:0], bus.rs1, bus.funct3, bus.rd, 7'b0010011};
        else
          enc = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, 7'b0010011};
      end
      C_JAL: begin
        enc   = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, 7'b1101111};
        legal = !bus.imm[0];
      end
      default:  legal = 1'b0;
    endcase
  end

  // Holding register: a legal accept loads (even while draining), a bare drain empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      instr_r <= 32'h0;
    end else if (clear) begin
      state   <= EMPTY;
      instr_r <= 32'h0;
    end else if (accept && legal) begin
      state   <= FULL;
      instr_r <= enc;
    end else if (xfer) begin
      state   <= EMPTY;
    end
  end

  // Address advances per completed transfer and wraps after DEPTH words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      addr_r <= BASE_ADDR;
    else if (clear)
      addr_r <= BASE_ADDR;
    else if (xfer)
      addr_r <= (addr_r == LAST_ADDR) ? BASE_ADDR : addr_r + 32'd4;
  end

  // Transfer counter survives clear; only reset zeroes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      words_r <= 16'h0;
    else if (xfer)
      words_r <= words_r + 16'd1;
  end

  // Single-cycle error pulse for an accepted but unencodable request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_r <= 1'b0;
    else
      err_r <= accept && !legal;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of the first emitted word.
REQ-002 SHALL have parameter DEPTH, default 64, meaning the number of words before out_addr wraps (DEPTH >= 2).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port clear  input  1  synchronous flush of the pending word and address.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready.
REQ-008 SHALL have port in_class  input  3  0=LOAD, 1=STORE, 2=RTYPE, 3=BRANCH, 4=ITYPE, 5=JAL; 6 and 7 are illegal.
REQ-009 SHALL have ports funct3 (input, 3), funct7b5 (input, 1), rd, rs1 and rs2 (input, 5 each), and imm (input, 32, signed byte offset or immediate).
REQ-010 SHALL have port out_valid  output  1  encoded word held.
REQ-011 SHALL have port out_ready  input  1  consumer (instruction-memory writer) takes the word when out_valid && out_ready.
REQ-012 SHALL have port out_instr  output  32  encoded RV32I word.
REQ-013 SHALL have port out_addr  output  32  byte address for out_instr.
REQ-014 SHALL have port err  output  1  one-cycle pulse on a rejected request.
REQ-015 SHALL have port words_out  output  16  count of completed output transfers, wrapping modulo 2^16.

Function
REQ-016 SHALL implement a two-state FSM, EMPTY and FULL; out_valid=1 exactly in FULL.
REQ-017 SHALL drive in_ready = !clear && (EMPTY || out_ready), so a word is accepted in the same cycle the held word drains.
REQ-018 SHALL register a legal accepted request into out_instr and enter or stay in FULL on the same edge, giving 1-cycle latency.
REQ-019 SHALL keep out_instr and out_addr stable while out_valid && !out_ready.
REQ-020 SHALL return to EMPTY on a transfer with no new legal accept.
REQ-021 SHALL encode LOAD as imm[11:0], rs1, funct3, rd, 0000011.
REQ-022 SHALL encode STORE as imm[11:5], rs2, rs1, funct3, imm[4:0], 0100011.
REQ-023 SHALL encode RTYPE as {0, funct7b5, 00000}, rs2, rs1, funct3, rd, 0110011.
REQ-024 SHALL encode BRANCH as imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 1100011.
REQ-025 SHALL encode ITYPE as imm[11:0], rs1, funct3, rd, 0010011; when funct3=101 bits 31:25 SHALL be {0, funct7b5, 00000} and bits 24:20 SHALL be imm[4:0].
REQ-026 SHALL encode JAL as imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111.
REQ-027 SHALL treat an accepted request as illegal when in_class is 6 or 7, or when in_class is BRANCH or JAL with imm[0]=1.
REQ-028 SHALL, for an illegal request, not load it, pulse err for one cycle, and leave the address unchanged; an output transfer in the same cycle still completes.
REQ-029 SHALL ignore imm bits above each format's field, with no range check.
REQ-030 SHALL start out_addr at BASE_ADDR, increment it by 4 after each output transfer, and wrap it from BASE_ADDR+4*(DEPTH-1) to BASE_ADDR.
REQ-031 SHALL increment words_out on each output transfer.
REQ-032 SHALL, on clear, force EMPTY, discard the held word, set out_addr=BASE_ADDR, and leave words_out unchanged.
REQ-033 SHALL give clear priority over simultaneous in_valid and out_ready, so no accept and no transfer occur.

Reset
REQ-034 SHALL, while rst_n=0, immediately force EMPTY, out_valid=0, in_ready=0, out_instr=0, out_addr=BASE_ADDR, words_out=0 and err=0, independent of clk.
REQ-035 SHALL discard any held word on reset mid-operation and resume at BASE_ADDR after rst_n rises.

Verification
REQ-036 SHALL pass: LOAD rd=6 rs1=9 funct3=010 imm=-4 -> out_instr=0xFFC4A303, out_addr=BASE_ADDR, one cycle after accept.
REQ-037 SHALL pass: back-to-back STORE rs2=6 rs1=9 funct3=010 imm=8, then RTYPE rd=4 rs1=5 rs2=6 funct3=110, with out_ready=1 -> 0x0064A423 @0x0, then 0x0062E233 @0x4, and in_ready stays 1.
REQ-038 SHALL pass: BRANCH rs1=rs2=4 funct3=000 imm=12 with out_ready=0 for 3 cycles -> 0x00420663 held stable, in_ready=0, then one transfer with words_out=1.
REQ-039 SHALL pass: JAL rd=1 imm=16 -> 0x010000EF; JAL imm=17 -> err pulses once, no out_valid, address unchanged.
REQ-040 SHALL pass: DEPTH=4 with 5 legal words streamed -> addresses 0x0, 0x4, 0x8, 0xC, 0x0 and words_out=5.
REQ-041 SHALL pass: clear asserted together with in_valid while FULL -> EMPTY next cycle, out_addr=BASE_ADDR, no accept; rst_n pulsed low mid-stall -> all outputs at reset values asynchronously.
